qspi_parallelizer: RTL and testbench

- Front-end distributor between a 4-bit QSPI slave stream and a bank of NUM_ENCRYPTERS encrypter cores.
- In program mode it assembles a key from nibbles and hands it to every encrypter, each with its own key-rotation index.
- In run mode it assembles ENCRYPTER_WIDTH-bit data packets from nibbles and dispatches them round-robin to encrypters that report ready.

---
 rtl/qspi_parallelizer.sv | 166 ++++++++++++++++
 tb/tb_qspi_parallelizer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_parallelizer.sv
// Nibble-serial front end that programs a key into every encrypter core and then
// deals assembled data packets to the cores round-robin, stalling on a busy target.
module qspi_parallelizer #(
   parameter int NUM_ENCRYPTERS     = 4,
   parameter int ENCRYPTER_WIDTH    = 32,
   parameter int KEY_WIDTH          = 32,
   parameter int KEY_ROTATION_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [3:0]                    qspi_data,
   input  logic                          qspi_sending,
   output logic                          qspi_ready,
   input  logic                          prog,
   output logic [ENCRYPTER_WIDTH-1:0]    encrypters_data,
   output logic [KEY_ROTATION_WIDTH-1:0] encrypters_key_rotation,
   output logic [NUM_ENCRYPTERS-1:0]     encrypters_program,
   output logic [NUM_ENCRYPTERS-1:0]     encrypters_data_ready,
   input  logic [NUM_ENCRYPTERS-1:0]     encrypters_ready,
   output logic [2:0]                    state_out
);

   localparam int KEY_NIB  = KEY_WIDTH / 4;
   localparam int DATA_NIB = ENCRYPTER_WIDTH / 4;
   localparam int KCW      = $clog2(KEY_NIB + 1);
   localparam int DCW      = $clog2(DATA_NIB + 1);
   localparam int IW       = $clog2(NUM_ENCRYPTERS);
   localparam logic [NUM_ENCRYPTERS-1:0] ONE_HOT0 = {{(NUM_ENCRYPTERS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_KEY_LOAD  = 3'd1,
      S_KEY_SEND  = 3'd2,
      S_DATA_LOAD = 3'd3,
      S_DATA_SEND = 3'd4
   } state_t;

   state_t                        state_q, state_d;
   logic [KCW-1:0]                key_cnt_q, key_cnt_d;
   logic [KEY_WIDTH-1:0]          key_q, key_d;
   logic [DCW-1:0]                data_cnt_q, data_cnt_d;
   logic [ENCRYPTER_WIDTH-1:0]    pkt_q, pkt_d;
   logic [KEY_ROTATION_WIDTH-1:0] rot_q, rot_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic [ENCRYPTER_WIDTH-1:0]    enc_data_q, enc_data_d;
   logic [KEY_ROTATION_WIDTH-1:0] enc_rot_q, enc_rot_d;
   logic [NUM_ENCRYPTERS-1:0]     enc_prog_q, enc_prog_d;
   logic [NUM_ENCRYPTERS-1:0]     enc_dvld_q, enc_dvld_d;
   logic [IW-1:0]                 rot_sel;

   assign rot_sel = rot_q[IW-1:0];

   always_comb begin
      state_d    = state_q;
      key_cnt_d  = key_cnt_q;
      key_d      = key_q;
      data_cnt_d = data_cnt_q;
      pkt_d      = pkt_q;
      rot_d      = rot_q;
      idx_d      = idx_q;
      enc_data_d = enc_data_q;
      enc_rot_d  = enc_rot_q;
      enc_prog_d = '0;
      enc_dvld_d = '0;

      case (state_q)
         S_IDLE: begin
            // The nibble that wakes us up is not consumed; DATA_LOAD takes it next edge.
            if (prog) begin
               state_d   = S_KEY_LOAD;
               key_cnt_d = '0;
            end else if (qspi_sending) begin
               state_d = S_DATA_LOAD;
            end
         end

         S_KEY_LOAD: begin
            if (qspi_sending) begin
               key_d = {key_q[KEY_WIDTH-5:0], qspi_data};
               if (key_cnt_q == KCW'(KEY_NIB - 1)) begin
                  state_d   = S_KEY_SEND;
                  key_cnt_d = '0;
                  rot_d     = '0;
               end else begin
                  key_cnt_d = key_cnt_q + KCW'(1);
               end
            end
         end

         S_KEY_SEND: begin
            if (encrypters_ready[rot_sel]) begin
               enc_data_d = ENCRYPTER_WIDTH'(key_q);
               enc_rot_d  = rot_q;
               enc_prog_d = ONE_HOT0 << rot_sel;
               if (rot_sel == IW'(NUM_ENCRYPTERS - 1)) begin
                  state_d = S_IDLE;
                  rot_d   = '0;
               end else begin
                  rot_d = rot_q + KEY_ROTATION_WIDTH'(1);
               end
            end
         end

         S_DATA_LOAD: begin
            if (qspi_sending) begin
               pkt_d      = {pkt_q[ENCRYPTER_WIDTH-5:0], qspi_data};
               data_cnt_d = data_cnt_q + DCW'(1);
               if (data_cnt_q == DCW'(DATA_NIB - 1)) begin
                  state_d = S_DATA_SEND;
               end
            end else if (data_cnt_q == '0) begin
               state_d = S_IDLE;
            end
         end

         S_DATA_SEND: begin
            // Strict round-robin: wait on the current target rather than skip ahead.
            if (encrypters_ready[idx_q]) begin
               enc_data_d = pkt_q;
               enc_dvld_d = ONE_HOT0 << idx_q;
               data_cnt_d = '0;
               idx_d      = (idx_q == IW'(NUM_ENCRYPTERS - 1)) ? '0 : idx_q + IW'(1);
               state_d    = qspi_sending ? S_DATA_LOAD : S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         key_cnt_q  <= '0;
         key_q      <= '0;
         data_cnt_q <= '0;
         pkt_q      <= '0;
         rot_q      <= '0;
         idx_q      <= '0;
         enc_data_q <= '0;
         enc_rot_q  <= '0;
         enc_prog_q <= '0;
         enc_dvld_q <= '0;
      end else begin
         state_q    <= state_d;
         key_cnt_q  <= key_cnt_d;
         key_q      <= key_d;
         data_cnt_q <= data_cnt_d;
         pkt_q      <= pkt_d;
         rot_q      <= rot_d;
         idx_q      <= idx_d;
         enc_data_q <= enc_data_d;
         enc_rot_q  <= enc_rot_d;
         enc_prog_q <= enc_prog_d;
         enc_dvld_q <= enc_dvld_d;
      end
   end

   assign qspi_ready              = (state_q == S_KEY_LOAD) || (state_q == S_DATA_LOAD);
   assign encrypters_data         = enc_data_q;
   assign encrypters_key_rotation = enc_rot_q;
   assign encrypters_program      = enc_prog_q;
   assign encrypters_data_ready   = enc_dvld_q;
   assign state_out               = state_q;

endmodule

// File: tb/tb_qspi_parallelizer.sv
// Directed bench for qspi_parallelizer: key fan-out, key stall, round-robin dispatch,
// ready back-pressure and mid-stream reset, with hand-computed expectations.
module tb_qspi_parallelizer;

   logic        clk;
   logic        reset;
   logic [3:0]  qspi_data;
   logic        qspi_sending;
   logic        qspi_ready;
   logic        prog;
   logic [31:0] encrypters_data;
   logic [1:0]  encrypters_key_rotation;
   logic [3:0]  encrypters_program;
   logic [3:0]  encrypters_data_ready;
   logic [3:0]  encrypters_ready;
   logic [2:0]  state_out;

   int vectors     = 0;
   int miscompares = 0;

   // Encrypter model state: each core goes busy for 4 cycles after a packet.
   bit          model_on = 0;
   int          busy [4];
   logic [3:0]  hold = '0;
   logic [3:0]  dr_log [$];
   logic [31:0] dd_log [$];
   bit          prev_dr  = 0;
   int          wide_cnt = 0;

   qspi_parallelizer #(
      .NUM_ENCRYPTERS    (4),
      .ENCRYPTER_WIDTH   (32),
      .KEY_WIDTH         (32),
      .KEY_ROTATION_WIDTH(2)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .qspi_data              (qspi_data),
      .qspi_sending           (qspi_sending),
      .qspi_ready             (qspi_ready),
      .prog                   (prog),
      .encrypters_data        (encrypters_data),
      .encrypters_key_rotation(encrypters_key_rotation),
      .encrypters_program     (encrypters_program),
      .encrypters_data_ready  (encrypters_data_ready),
      .encrypters_ready       (encrypters_ready),
      .state_out              (state_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_ready();
      for (int k = 0; k < 4; k++)
         encrypters_ready[k] = (busy[k] == 0) && !hold[k];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (|encrypters_data_ready) begin
         dr_log.push_back(encrypters_data_ready);
         dd_log.push_back(encrypters_data);
         if (prev_dr) wide_cnt++;
      end
      prev_dr = |encrypters_data_ready;
      if (model_on) begin
         for (int k = 0; k < 4; k++) begin
            if (encrypters_data_ready[k]) busy[k] = 4;
            else if (busy[k] != 0)       busy[k] = busy[k] - 1;
         end
         apply_ready();
      end
   endtask

   // Present one nibble and hold it until the DUT takes it at an edge.
   task automatic push_nib(input logic [3:0] v);
      logic take;
      int   guard;
      take  = 1'b0;
      guard = 0;
      qspi_data    = v;
      qspi_sending = 1'b1;
      while (!take && guard < 60) begin
         take = qspi_ready;
         tick();
         guard++;
      end
      if (!take) chk("nib_accept", take, 1);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int j = 0; j < 8; j++) push_nib(w[31-4*j -: 4]);
   endtask

   function automatic logic [31:0] rr_word(input int p);
      logic [31:0] v;
      v = '0;
      for (int j = 0; j < 8; j++) v = {v[27:0], 4'((8 * p + j) % 16)};
      return v;
   endfunction

   initial begin
      logic [31:0] kw;
      reset = 1'b1; prog = 1'b0; qspi_sending = 1'b0; qspi_data = '0;
      encrypters_ready = 4'hF;
      for (int k = 0; k < 4; k++) busy[k] = 0;

      // Reset state
      tick(); tick();
      chk("rst_state", state_out, 0);
      chk("rst_qspi_ready", qspi_ready, 0);
      chk("rst_program", encrypters_program, 0);
      chk("rst_data_ready", encrypters_data_ready, 0);
      chk("rst_data", encrypters_data, 0);
      chk("rst_rotation", encrypters_key_rotation, 0);
      reset = 1'b0;
      tick();

      // Key program, all encrypters ready
      prog = 1'b1;
      tick();
      chk("key_state_load", state_out, 1);
      chk("key_qspi_ready", qspi_ready, 1);
      prog = 1'b0;
      qspi_sending = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         qspi_data = 4'(i);
         tick();
      end
      chk("key_state_send", state_out, 2);
      qspi_sending = 1'b0;
      for (int r = 0; r < 4; r++) begin
         tick();
         chk("key_program", encrypters_program, 64'(1) << r);
         chk("key_rotation", encrypters_key_rotation, r);
         chk("key_data", encrypters_data, 32'h12345678);
         chk("key_no_data_ready", encrypters_data_ready, 0);
      end
      chk("key_done_idle", state_out, 0);
      tick();
      chk("key_program_clear", encrypters_program, 0);

      // Key stall: each write waits for its own ready bit
      encrypters_ready = 4'h0;
      prog = 1'b1;
      tick();
      prog = 1'b0;
      kw = 32'hABCDEF01;
      qspi_sending = 1'b1;
      for (int j = 0; j < 8; j++) begin
         qspi_data = kw[31-4*j -: 4];
         tick();
      end
      qspi_sending = 1'b0;
      chk("stall_state_send", state_out, 2);
      for (int i = 0; i < 4; i++) begin
         encrypters_ready = 4'h0;
         tick();
         chk("stall_no_program", encrypters_program, 0);
         chk("stall_state_hold", state_out, 2);
         encrypters_ready = 4'(1 << i);
         tick();
         chk("stall_program", encrypters_program, 64'(1) << i);
         chk("stall_rotation", encrypters_key_rotation, i);
         chk("stall_data", encrypters_data, 32'hABCDEF01);
      end
      chk("stall_done_idle", state_out, 0);

      // Round-robin dispatch of five packets with busy encrypters
      model_on = 1;
      hold = '0;
      apply_ready();
      dr_log.delete();
      dd_log.delete();
      for (int p = 0; p < 5; p++) push_word(rr_word(p));
      qspi_sending = 1'b0;
      tick();
      tick();
      chk("rr_count", dr_log.size(), 5);
      for (int p = 0; p < 5 && p < dr_log.size(); p++) begin
         chk("rr_strobe", dr_log[p], 64'(1) << (p % 4));
         chk("rr_data", dd_log[p], rr_word(p));
      end
      chk("rr_first_packet", rr_word(0), 32'h01234567);
      chk("rr_strobe_width", wide_cnt, 0);
      chk("rr_idle", state_out, 0);

      // Back-pressure on encrypter 1: nibbles offered during the stall are ignored
      hold[1] = 1'b1;
      apply_ready();
      dr_log.delete();
      push_word(32'hFEDCBA98);
      for (int c = 0; c < 3; c++) begin
         qspi_data = 4'h5;
         qspi_sending = 1'b1;
         tick();
         chk("bp_state_send", state_out, 4);
         chk("bp_qspi_ready", qspi_ready, 0);
         chk("bp_no_strobe", encrypters_data_ready, 0);
      end
      hold[1] = 1'b0;
      apply_ready();
      tick();
      chk("bp_strobe", encrypters_data_ready, 4'b0010);
      chk("bp_data", encrypters_data, 32'hFEDCBA98);
      chk("bp_state_load", state_out, 3);
      push_word(32'h76543210);
      qspi_sending = 1'b0;
      tick();
      chk("bp_next_strobe", encrypters_data_ready, 4'b0100);
      chk("bp_next_data", encrypters_data, 32'h76543210);
      chk("bp_idle", state_out, 0);

      // Mid-stream reset after three nibbles of a packet
      push_nib(4'h1);
      push_nib(4'h2);
      push_nib(4'h3);
      qspi_sending = 1'b0;
      tick();
      chk("mr_partial_wait", state_out, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_state", state_out, 0);
      chk("mr_qspi_ready", qspi_ready, 0);
      chk("mr_data", encrypters_data, 0);
      chk("mr_strobe", encrypters_data_ready, 0);
      push_word(32'hCAFEF00D);
      qspi_sending = 1'b0;
      tick();
      chk("mr_idx0_strobe", encrypters_data_ready, 4'b0001);
      chk("mr_packet", encrypters_data, 32'hCAFEF00D);
      chk("mr_idle", state_out, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
